// File: rtl/axi_slave_mem.sv
// AXI4 slave memory responder: independent write (AW/W/B) and read (AR/R) engines
// over a word-addressed RAM with FIXED/INCR/WRAP bursts, byte strobes and SLVERR.
module axi_slave_mem #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ID_WIDTH   = 16,
   parameter int unsigned           MEM_DEPTH  = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ID_WIDTH-1:0]     AWID,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic [7:0]              AWLEN,
   input  logic [2:0]              AWSIZE,
   input  logic [1:0]              AWBURST,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    WLAST,
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic [ID_WIDTH-1:0]     BID,
   output logic [1:0]              BRESP,
   output logic                    BVALID,
   input  logic                    BREADY,
   input  logic [ID_WIDTH-1:0]     ARID,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic [7:0]              ARLEN,
   input  logic [2:0]              ARSIZE,
   input  logic [1:0]              ARBURST,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [ID_WIDTH-1:0]     RID,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP,
   output logic                    RLAST,
   output logic                    RVALID,
   input  logic                    RREADY
);
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned OFFS   = $clog2(STRB_W);
   localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   function automatic logic burst_bad(input logic [2:0] size, input logic [7:0] len,
                                      input logic [1:0] burst);
      return (size > 3'(OFFS)) || (burst == 2'b11) ||
             ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
   endfunction

   function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] off;
      off = addr - BASE_ADDR;
      return (addr >= BASE_ADDR) && ((off >> OFFS) < ADDR_WIDTH'(MEM_DEPTH));
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] off;
      off = (addr - BASE_ADDR) >> OFFS;
      return off[IDX_W-1:0];
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [2:0] size,
                                                       input logic [7:0] len,
                                                       input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] step, mask, nxt;
      step = ADDR_WIDTH'(1) << size;
      mask = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * step - ADDR_WIDTH'(1);
      case (burst)
         2'b01:   nxt = addr + step;
         2'b10:   nxt = (addr & ~mask) | ((addr + step) & mask);
         default: nxt = addr;
      endcase
      return nxt;
   endfunction

   w_state_e              w_state_q, w_state_d;
   logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [ID_WIDTH-1:0]   bid_q, bid_d;
   logic [1:0]            bresp_q, bresp_d, w_burst_q, w_burst_d;
   logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
   logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
   logic [2:0]            w_size_q, w_size_d;
   logic                  w_err_q, w_err_d, w_berr_q, w_berr_d;
   logic                  mem_we, w_beat_ok;
   logic [IDX_W-1:0]      mem_widx;

   r_state_e              r_state_q, r_state_d;
   logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [ID_WIDTH-1:0]   rid_q, rid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d, r_word;
   logic [1:0]            rresp_q, rresp_d, r_burst_q, r_burst_d;
   logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, r_src_addr;
   logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
   logic [2:0]            r_size_q, r_size_d;
   logic                  r_berr_q, r_berr_d, r_src_berr, r_beat_ok;

   // Write engine: address latch, strobed beat writes, single B response.
   always_comb begin
      w_state_d = w_state_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bid_d     = bid_q;
      bresp_d   = bresp_q;
      w_addr_d  = w_addr_q;
      w_len_d   = w_len_q;
      w_size_d  = w_size_q;
      w_burst_d = w_burst_q;
      w_cnt_d   = w_cnt_q;
      w_err_d   = w_err_q;
      w_berr_d  = w_berr_q;
      mem_we    = 1'b0;
      mem_widx  = word_idx(w_addr_q);
      w_beat_ok = addr_ok(w_addr_q) && !w_berr_q;
      case (w_state_q)
         W_IDLE: begin
            awready_d = 1'b1;
            if (AWVALID && awready_q) begin
               bid_d     = AWID;
               w_addr_d  = AWADDR;
               w_len_d   = AWLEN;
               w_size_d  = AWSIZE;
               w_burst_d = AWBURST;
               w_cnt_d   = 8'd0;
               w_berr_d  = burst_bad(AWSIZE, AWLEN, AWBURST);
               w_err_d   = w_berr_d;
               awready_d = 1'b0;
               wready_d  = 1'b1;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (WVALID && wready_q) begin
               mem_we   = w_beat_ok && !rst;
               w_err_d  = w_err_q || !w_beat_ok || (WLAST != (w_cnt_q == w_len_q));
               w_addr_d = next_addr(w_addr_q, w_size_q, w_len_q, w_burst_q);
               w_cnt_d  = w_cnt_q + 8'd1;
               if (w_cnt_q == w_len_q) begin
                  wready_d  = 1'b0;
                  bvalid_d  = 1'b1;
                  bresp_d   = w_err_d ? 2'b10 : 2'b00;
                  w_state_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (BREADY && bvalid_q) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read engine: beat 0 is loaded at the AR handshake, later beats on each R handshake.
   always_comb begin
      r_state_d  = r_state_q;
      arready_d  = arready_q;
      rvalid_d   = rvalid_q;
      rlast_d    = rlast_q;
      rid_d      = rid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      r_addr_d   = r_addr_q;
      r_len_d    = r_len_q;
      r_size_d   = r_size_q;
      r_burst_d  = r_burst_q;
      r_cnt_d    = r_cnt_q;
      r_berr_d   = r_berr_q;
      r_src_addr = (r_state_q == R_IDLE) ? ARADDR : r_addr_q;
      r_src_berr = (r_state_q == R_IDLE) ? burst_bad(ARSIZE, ARLEN, ARBURST) : r_berr_q;
      r_beat_ok  = addr_ok(r_src_addr) && !r_src_berr;
      r_word     = mem[word_idx(r_src_addr)];
      case (r_state_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (ARVALID && arready_q) begin
               rid_d     = ARID;
               r_len_d   = ARLEN;
               r_size_d  = ARSIZE;
               r_burst_d = ARBURST;
               r_berr_d  = r_src_berr;
               r_cnt_d   = 8'd0;
               rdata_d   = r_beat_ok ? r_word : '0;
               rresp_d   = r_beat_ok ? 2'b00 : 2'b10;
               rlast_d   = (ARLEN == 8'd0);
               r_addr_d  = next_addr(ARADDR, ARSIZE, ARLEN, ARBURST);
               arready_d = 1'b0;
               rvalid_d  = 1'b1;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (RREADY && rvalid_q) begin
               if (rlast_q) begin
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  arready_d = 1'b1;
                  r_state_d = R_IDLE;
               end else begin
                  r_cnt_d  = r_cnt_q + 8'd1;
                  rdata_d  = r_beat_ok ? r_word : '0;
                  rresp_d  = r_beat_ok ? 2'b00 : 2'b10;
                  rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
                  r_addr_d = next_addr(r_addr_q, r_size_q, r_len_q, r_burst_q);
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= 2'b00;
         w_addr_q  <= '0;
         w_len_q   <= 8'd0;
         w_size_q  <= 3'd0;
         w_burst_q <= 2'b00;
         w_cnt_q   <= 8'd0;
         w_err_q   <= 1'b0;
         w_berr_q  <= 1'b0;
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rdata_q   <= '0;
         rresp_q   <= 2'b00;
         r_addr_q  <= '0;
         r_len_q   <= 8'd0;
         r_size_q  <= 3'd0;
         r_burst_q <= 2'b00;
         r_cnt_q   <= 8'd0;
         r_berr_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bid_q     <= bid_d;
         bresp_q   <= bresp_d;
         w_addr_q  <= w_addr_d;
         w_len_q   <= w_len_d;
         w_size_q  <= w_size_d;
         w_burst_q <= w_burst_d;
         w_cnt_q   <= w_cnt_d;
         w_err_q   <= w_err_d;
         w_berr_q  <= w_berr_d;
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rid_q     <= rid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         r_addr_q  <= r_addr_d;
         r_len_q   <= r_len_d;
         r_size_q  <= r_size_d;
         r_burst_q <= r_burst_d;
         r_cnt_q   <= r_cnt_d;
         r_berr_q  <= r_berr_d;
      end
   end

   // Storage is not reset; a same-cycle read sees the value before this write.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < STRB_W; b++) begin
            if (WSTRB[b]) mem[mem_widx][8*b +: 8] <= WDATA[8*b +: 8];
         end
      end
   end

   assign AWREADY = awready_q;
   assign WREADY  = wready_q;
   assign BVALID  = bvalid_q;
   assign BID     = bid_q;
   assign BRESP   = bresp_q;
   assign ARREADY = arready_q;
   assign RVALID  = rvalid_q;
   assign RLAST   = rlast_q;
   assign RID     = rid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- Parametrised, synthesizable AXI4 slave memory responder. It is the RTL counterpart to the master VIP interface and serves as loopback DUT and reference target for master-side sequences.
- Implements independent write (AW/W/B) and read (AR/R) FSMs over a word-addressed memory.
- Supports FIXED, INCR and WRAP bursts, WSTRB byte enables, ID echo and SLVERR reporting.
- Adds full 2-bit RRESP, burst address generation and error checking.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 32, data bus width; power of 2, 8..1024
ID_WIDTH, 16, transaction ID width
MEM_DEPTH, 1024, memory depth in DATA_WIDTH words
BASE_ADDR, 0, byte address mapped to word 0; must be aligned to DATA_WIDTH/8

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-high reset
AWID  input  ID_WIDTH  write ID
AWADDR  input  ADDR_WIDTH  write start address
AWLEN  input  8  beats minus 1
AWSIZE  input  3  log2 bytes per beat
AWBURST  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
AWVALID  input  1  AW valid
AWREADY  output  1  AW ready
WDATA  input  DATA_WIDTH  write data
WSTRB  input  DATA_WIDTH/8  byte enables
WLAST  input  1  last write beat
WVALID  input  1  W valid
WREADY  output  1  W ready
BID  output  ID_WIDTH  response ID
BRESP  output  2  00 OKAY, 10 SLVERR
BVALID  output  1  B valid
BREADY  input  1  B ready
ARID  input  ID_WIDTH  read ID
ARADDR  input  ADDR_WIDTH  read start address
ARLEN  input  8  beats minus 1
ARSIZE  input  3  log2 bytes per beat
ARBURST  input  2  burst type
ARVALID  input  1  AR valid
ARREADY  output  1  AR ready
RID  output  ID_WIDTH  read ID
RDATA  output  DATA_WIDTH  read data
RRESP  output  2  00 OKAY, 10 SLVERR
RLAST  output  1  last read beat
RVALID  output  1  R valid
RREADY  input  1  R ready

Behaviour:
- Reset: while rst=1, all outputs are 0 and both FSMs go to IDLE. Memory contents are not reset.
- Reset mid-burst aborts the burst without a B or R response. Beats already written are retained.
- Write FSM states:
  - W_IDLE: AWREADY=1. On AWVALID, latch AWID, AWADDR, AWLEN, AWSIZE, AWBURST, clear the beat counter and error flag, then go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID beat writes the bytes whose WSTRB bit is set to the current word, when the address is legal. On the beat where count==len, go to W_RESP.
  - W_RESP: BVALID=1 with BID=latched ID and BRESP=00, or 10 if the error flag is set. Return to W_IDLE on BREADY.
- AWREADY=0 outside W_IDLE; WREADY=0 outside W_DATA.
- W beats arriving before the AW handshake are not accepted.
- Read FSM states:
  - R_IDLE: ARREADY=1. On ARVALID, latch the request and load beat 0 into the output registers, then go to R_DATA.
  - R_DATA: RVALID=1. RID, RDATA, RRESP and RLAST are held stable while RREADY=0.
  - On each RREADY beat the next beat is loaded. Back-to-back beats run at 1 per cycle. After the RLAST beat, return to R_IDLE.
- Read latency: with the AR handshake on edge N, the first beat is valid after edge N; the first RVALID cycle is N+1.
- Address sequence, with bytes per beat B=2^size:
  - FIXED: address constant.
  - INCR: addr+B per beat.
  - WRAP: boundary=(len+1)*B; next=(addr & ~(boundary-1)) | ((addr+B) & (boundary-1)).
- Word index = (addr-BASE_ADDR) >> log2(DATA_WIDTH/8).
- Error conditions, each setting SLVERR and suppressing the write or returning RDATA=0 for the beat:
  - addr<BASE_ADDR or index>=MEM_DEPTH (per beat);
  - size>log2(DATA_WIDTH/8) (whole burst);
  - burst=11 (whole burst);
  - WRAP with len not in {1,3,7,15} (whole burst).
- Read errors are reported per beat on RRESP.
- WLAST protocol check:
  - WLAST=1 on a non-final beat, or WLAST=0 on the final beat, sets SLVERR.
  - The burst always ends on the counted beat.
- Simultaneous read and write of the same word in one cycle: the read returns the pre-write value.
- Write and read channels operate fully concurrently, one outstanding transaction per channel.

Test Plan:
- INCR write, AWADDR=0x10, AWLEN=3, AWSIZE=2, WSTRB=F, data 0xA0..0xA3, then read of the same burst -> BRESP=00, BID echoed; RDATA=0xA0..0xA3; RLAST only on beat 3; first RVALID one cycle after the AR handshake.
- WRAP read with ARADDR=0x18, ARLEN=3, ARSIZE=2 -> word addresses 0x18, 0x1C, 0x10, 0x14.
- Partial strobe: write 0x11223344 with WSTRB=0x5 over a word holding 0xFFFFFFFF -> readback 0xFF22FF44.
- Out-of-range INCR burst starting at the last word, len=1 -> beat 0 OKAY and written, beat 1 not written; BRESP=10; read of the same burst gives RRESP 00 then 10 with RDATA=0 on beat 1.
- RREADY toggled 1-0-0-1 during a read -> RDATA and RID stable while stalled, no beat lost or duplicated.
- Early WLAST on beat 1 of a len=3 burst -> all 4 beats accepted, BRESP=10. Then rst pulsed mid-read -> RVALID=0 on the next cycle and ARREADY=1 after rst falls.
